// File: rtl/parity_run_pkg.sv
// Shared encodings and width helper for the parity run detector.
package parity_run_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_HIT    = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    HIT    = ST_HIT,
    HOLD   = ST_HOLD
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parity_run_detector_if.sv
// Sample/result bundle of the parity run detector, plus the FSM state for observation.
interface parity_run_detector_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) ();

  // Samples are presented every cycle; in_valid qualifies x_in (no backpressure, no ready).
  logic [WIDTH-1:0] x_in;
  logic             in_valid;
  logic             match_sel;
  logic             cnt_clr;
  logic             y_out;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output x_in, in_valid, match_sel, cnt_clr,
    input  y_out, busy, hit_cnt, state_dbg
  );

  modport slave (
    input  x_in, in_valid, match_sel, cnt_clr,
    output y_out, busy, hit_cnt, state_dbg
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/parity_run_detector.sv
// Pulses y_out one cycle after RUN_LEN consecutive valid samples of the selected
// parity, then ignores input for HOLDOFF cycles; counts hits with saturation.
module parity_run_detector
  import parity_run_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int RUN_LEN = 1,
  parameter int HOLDOFF = 1,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_run_detector_if.slave bus
);

  localparam int RUN_W  = cnt_width(RUN_LEN);
  localparam int HOLD_W = cnt_width(HOLDOFF);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLDOFF >= 2) ? (HOLDOFF - 1) : 1);

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  sample;
  logic              match;
  logic              hit_inc;

  assign sample = bus.x_in;
  assign match  = bus.in_valid & ((^sample) == bus.match_sel);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hold_d  = hold_q;
    hit_inc = 1'b0;
    case (state_q)
      SEARCH: begin
        if (match) begin
          if (run_q == RUN_LAST) begin
            state_d = HIT;
            run_d   = '0;
            hit_inc = 1'b1;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else if (bus.in_valid) begin
          run_d = '0;
        end
      end
      HIT: begin
        run_d = '0;
        if (HOLDOFF == 0) begin
          // Without holdoff the hit-cycle sample starts a fresh run immediately.
          state_d = SEARCH;
          if (match) begin
            if (RUN_LEN == 1) begin
              state_d = HIT;
              hit_inc = 1'b1;
            end else begin
              run_d = RUN_W'(1);
            end
          end
        end else if (HOLDOFF == 1) begin
          state_d = SEARCH;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = SEARCH;
          run_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      run_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc),
    .clr (bus.cnt_clr),
    .q   (bus.hit_cnt)
  );

  assign bus.y_out     = (state_q == HIT);
  assign bus.busy      = (state_q != SEARCH);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_parity_run_detector.sv
// Directed bench: four detector configurations driven from one linear sequence.
module tb_parity_run_detector;
  import parity_run_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  parity_run_detector_if #(.WIDTH(2), .CNT_W(8)) ifa ();
  parity_run_detector_if #(.WIDTH(2), .CNT_W(8)) ifb ();
  parity_run_detector_if #(.WIDTH(2), .CNT_W(8)) ifc ();
  parity_run_detector_if #(.WIDTH(2), .CNT_W(2)) ifd ();

  parity_run_detector #(.WIDTH(2), .RUN_LEN(1), .HOLDOFF(1), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  parity_run_detector #(.WIDTH(2), .RUN_LEN(3), .HOLDOFF(0), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
  parity_run_detector #(.WIDTH(2), .RUN_LEN(1), .HOLDOFF(4), .CNT_W(8))
    dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave));
  parity_run_detector #(.WIDTH(2), .RUN_LEN(1), .HOLDOFF(0), .CNT_W(2))
    dut_d (.clk(clk), .rst(rst_d), .bus(ifd.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] x_seq [6];
  logic       v_seq [6];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    ifa.x_in = 2'b00; ifa.in_valid = 1'b1; ifa.match_sel = 1'b0; ifa.cnt_clr = 1'b0;
    ifb.x_in = 2'b00; ifb.in_valid = 1'b1; ifb.match_sel = 1'b0; ifb.cnt_clr = 1'b0;
    ifc.x_in = 2'b11; ifc.in_valid = 1'b1; ifc.match_sel = 1'b0; ifc.cnt_clr = 1'b0;
    ifd.x_in = 2'b00; ifd.in_valid = 1'b1; ifd.match_sel = 1'b0; ifd.cnt_clr = 1'b0;
    tick();
    tick();
    check("rst_a_y",    ifa.y_out, 0);
    check("rst_a_busy", ifa.busy, 0);
    check("rst_a_cnt",  ifa.hit_cnt, 0);
    check("rst_b_st",   ifb.state_dbg, ST_SEARCH);
    check("rst_c_busy", ifc.busy, 0);
    check("rst_d_cnt",  ifd.hit_cnt, 0);

    // Defaults, even samples held: alternating pulses.
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_y_%0d", i),   ifa.y_out, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t1_cnt_%0d", i), ifa.hit_cnt, i / 2 + 1);
    end

    // Odd samples never match; then an even sample hits one cycle later.
    rst_a = 1'b1;
    tick();
    check("t2_rst_cnt", ifa.hit_cnt, 0);
    rst_a = 1'b0;
    ifa.x_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_y_%0d", i),   ifa.y_out, 0);
      check($sformatf("t2_cnt_%0d", i), ifa.hit_cnt, 0);
    end
    ifa.x_in = 2'b11;
    tick();
    check("t2_hit_y",   ifa.y_out, 1);
    check("t2_hit_cnt", ifa.hit_cnt, 1);
    check("t2_hit_st",  ifa.state_dbg, ST_HIT);
    tick();
    check("t2_after_y",    ifa.y_out, 0);
    check("t2_after_busy", ifa.busy, 0);

    // Reset while in HIT.
    ifa.x_in = 2'b00;
    tick();
    check("t6a_hit_y",    ifa.y_out, 1);
    check("t6a_hit_busy", ifa.busy, 1);
    rst_a = 1'b1;
    tick();
    check("t6a_rst_y",    ifa.y_out, 0);
    check("t6a_rst_busy", ifa.busy, 0);
    check("t6a_rst_cnt",  ifa.hit_cnt, 0);
    rst_a = 1'b0;
    tick();
    check("t6a_re_y",   ifa.y_out, 1);
    check("t6a_re_cnt", ifa.hit_cnt, 1);
    rst_a = 1'b1;

    // RUN_LEN=3, HOLDOFF=0: an odd sample breaks the run.
    rst_b = 1'b0;
    x_seq = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      ifb.x_in = x_seq[i];
      ifb.in_valid = 1'b1;
      tick();
      check($sformatf("t3_y_%0d", i), ifb.y_out, (i == 5) ? 1 : 0);
    end
    check("t3_cnt1", ifb.hit_cnt, 1);
    ifb.x_in = 2'b01;
    tick();
    check("t3_post_y",    ifb.y_out, 0);
    check("t3_post_busy", ifb.busy, 0);
    // Invalid cycles inside the run (with odd data on the bus) leave it intact.
    x_seq = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    v_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      ifb.x_in = x_seq[i];
      ifb.in_valid = v_seq[i];
      tick();
      check($sformatf("t3_gap_y_%0d", i), ifb.y_out, (i == 5) ? 1 : 0);
    end
    check("t3_cnt2", ifb.hit_cnt, 2);
    // With no holdoff, the HIT-cycle sample counts toward the next run.
    ifb.x_in = 2'b00;
    ifb.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_b2b_y_%0d", i), ifb.y_out, (i == 2) ? 1 : 0);
    end
    check("t3_cnt3", ifb.hit_cnt, 3);
    tick();
    tick();
    check("t6b_pre_y", ifb.y_out, 0);
    // Reset mid-run: the partial run is discarded.
    rst_b = 1'b1;
    tick();
    check("t6b_rst_y",   ifb.y_out, 0);
    check("t6b_rst_cnt", ifb.hit_cnt, 0);
    check("t6b_rst_st",  ifb.state_dbg, ST_SEARCH);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6b_re_y_%0d", i), ifb.y_out, (i == 2) ? 1 : 0);
    end
    rst_b = 1'b1;

    // RUN_LEN=1, HOLDOFF=4: busy spans HIT plus three HOLD cycles.
    rst_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t4_y_%0d", i),    ifc.y_out, (i % 5 == 0) ? 1 : 0);
      check($sformatf("t4_busy_%0d", i), ifc.busy, (i % 5 != 4) ? 1 : 0);
      check($sformatf("t4_cnt_%0d", i),  ifc.hit_cnt, i / 5 + 1);
    end
    check("t4_hold_st", ifc.state_dbg, ST_SEARCH);
    ifc.match_sel = 1'b1;
    tick();
    check("t4_odd_miss0", ifc.y_out, 0);
    tick();
    check("t4_odd_miss1", ifc.y_out, 0);
    ifc.x_in = 2'b01;
    tick();
    check("t4_odd_hit_y",   ifc.y_out, 1);
    check("t4_odd_hit_cnt", ifc.hit_cnt, 3);
    tick();
    check("t6c_hold_st",   ifc.state_dbg, ST_HOLD);
    check("t6c_hold_busy", ifc.busy, 1);
    rst_c = 1'b1;
    tick();
    check("t6c_rst_y",    ifc.y_out, 0);
    check("t6c_rst_busy", ifc.busy, 0);
    check("t6c_rst_cnt",  ifc.hit_cnt, 0);
    rst_c = 1'b0;
    tick();
    check("t6c_re_y",   ifc.y_out, 1);
    check("t6c_re_cnt", ifc.hit_cnt, 1);
    rst_c = 1'b1;

    // CNT_W=2, back-to-back hits: counter saturates at 3, clear beats increment.
    rst_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_y_%0d", i),   ifd.y_out, 1);
      check($sformatf("t5_cnt_%0d", i), ifd.hit_cnt, (i < 3) ? i + 1 : 3);
    end
    ifd.cnt_clr = 1'b1;
    tick();
    check("t5_clr_cnt", ifd.hit_cnt, 0);
    check("t5_clr_y",   ifd.y_out, 1);
    ifd.cnt_clr = 1'b0;
    tick();
    check("t5_after_clr_cnt", ifd.hit_cnt, 1);
    rst_d = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
